// File: rtl/conv_window_scheduler_pkg.sv
// Shared definitions for the convolution window scheduler.
//   sched_state_e : frame sequencing states
//   cnt_width()   : bit width able to hold 0..n-1, never less than one bit
package conv_window_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFlush = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } sched_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_position_counter.sv
// Tracks the (row, col) position of the next pixel in the frame plus the stride phase of
// that position, and flags whether accepting it completes a legal K x K window.
//   clock, sreset : clock, synchronous active-high reset
//   clear         : zero all counters (start of frame)
//   advance       : a pixel is accepted this cycle
//   row, col      : position of the pixel currently offered
//   qualify       : accepting the current pixel completes a window at the stride grid
//   last          : current pixel is the last one of the frame
module window_position_counter
    import conv_window_scheduler_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned ROW_SIZE    = 5,
    parameter int unsigned COLUMN_SIZE = 5,
    parameter int unsigned STRIDE      = 1,
    localparam int unsigned COL_W      = cnt_width(ROW_SIZE),
    localparam int unsigned ROW_W      = cnt_width(COLUMN_SIZE)
) (
    input  logic             clock,
    input  logic             sreset,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             qualify,
    output logic             last
);

    localparam int unsigned PH_W = cnt_width(STRIDE);
    localparam logic [COL_W-1:0] ColFirst = COL_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0] ColLast  = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0] RowFirst = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] RowLast  = ROW_W'(COLUMN_SIZE - 1);
    localparam logic [PH_W-1:0]  PhLast   = PH_W'(STRIDE - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PH_W-1:0]  pc_q, pc_d;
    logic [PH_W-1:0]  pr_q, pr_d;

    // Phase counters are pinned to 0 up to and including position K-1, then count modulo
    // STRIDE, so phase 0 marks every stride-aligned window origin.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        pc_d  = pc_q;
        pr_d  = pr_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
            pc_d  = '0;
            pr_d  = '0;
        end else if (advance) begin
            if (col_q == ColLast) begin
                col_d = '0;
                pc_d  = '0;
                // Row holds at the bottom; only a new frame returns it to 0.
                if (row_q != RowLast) begin
                    row_d = row_q + 1'b1;
                    if (row_q < RowFirst) begin
                        pr_d = '0;
                    end else begin
                        pr_d = (pr_q == PhLast) ? '0 : pr_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                if (col_q < ColFirst) begin
                    pc_d = '0;
                end else begin
                    pc_d = (pc_q == PhLast) ? '0 : pc_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (sreset) begin
            col_q <= '0;
            row_q <= '0;
            pc_q  <= '0;
            pr_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            pc_q  <= pc_d;
            pr_q  <= pr_d;
        end
    end

    assign row     = row_q;
    assign col     = col_q;
    assign qualify = (row_q >= RowFirst) & (col_q >= ColFirst) & (pr_q == '0) & (pc_q == '0);
    assign last    = (row_q == RowLast) & (col_q == ColLast);

endmodule

// File: rtl/conv_window_scheduler.sv
// Frame sequencer for a K x K sliding-window image buffer. Accepts a valid/ready pixel
// stream, drives the buffer shift/flush and presents each legal stride-aligned window
// with its top-left (row, col) tag under valid/ready backpressure.
//   clock, sreset        : clock, synchronous active-high reset
//   start                : arm a new frame (idle only)
//   pix_valid/pix_ready  : upstream pixel handshake
//   buf_shift            : buffer data_in_valid
//   buf_clear            : buffer flush (active while reset or for one cycle per frame)
//   win_valid/win_ready  : window handshake; win_row/win_col tag the window
//   frame_done           : one-cycle pulse at end of frame
//   busy                 : frame in progress
module conv_window_scheduler
    import conv_window_scheduler_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned ROW_SIZE    = 5,
    parameter int unsigned COLUMN_SIZE = 5,
    parameter int unsigned STRIDE      = 1,
    localparam int unsigned COL_W      = cnt_width(ROW_SIZE),
    localparam int unsigned ROW_W      = cnt_width(COLUMN_SIZE)
) (
    input  logic             clock,
    input  logic             sreset,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             buf_shift,
    output logic             buf_clear,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [ROW_W-1:0] win_row,
    output logic [COL_W-1:0] win_col,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [ROW_W-1:0] RowOfs = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0] ColOfs = COL_W'(KERNEL_SIZE - 1);

    sched_state_e     state_q, state_d;
    logic             win_valid_q, win_valid_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic             frame_done_q, frame_done_d;

    logic [ROW_W-1:0] pos_row;
    logic [COL_W-1:0] pos_col;
    logic             pos_qualify;
    logic             pos_last;
    logic             accept;
    logic             handshake;

    // A held window stalls the pixel stream so the buffer's kernel_out stays frozen.
    assign pix_ready = (state_q == StRun) & (~win_valid_q | win_ready);
    assign buf_shift = pix_ready & pix_valid;
    assign accept    = buf_shift;
    assign handshake = win_valid_q & win_ready;
    assign buf_clear = sreset | (state_q == StFlush);
    assign busy      = (state_q != StIdle);

    window_position_counter #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .ROW_SIZE    (ROW_SIZE),
        .COLUMN_SIZE (COLUMN_SIZE),
        .STRIDE      (STRIDE)
    ) u_pos (
        .clock   (clock),
        .sreset  (sreset),
        .clear   (state_q == StFlush),
        .advance (accept),
        .row     (pos_row),
        .col     (pos_col),
        .qualify (pos_qualify),
        .last    (pos_last)
    );

    always_comb begin
        state_d      = state_q;
        win_valid_d  = win_valid_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;

        // A new window may replace one being handed off in the same cycle.
        if (accept & pos_qualify) begin
            win_valid_d = 1'b1;
            win_row_d   = pos_row - RowOfs;
            win_col_d   = pos_col - ColOfs;
        end else if (handshake) begin
            win_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle:  if (start) state_d = StFlush;
            StFlush: state_d = StRun;
            StRun:   if (accept & pos_last) state_d = StDrain;
            StDrain: begin
                if (~win_valid_q | win_ready) begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sreset) begin
            state_q      <= StIdle;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: one instance at stride 1, one at stride 2, sharing
// inputs; `sel` picks which instance's outputs are observed.
module tb_conv_window_scheduler;

    localparam int K    = 3;
    localparam int RS   = 5;
    localparam int CS   = 5;
    localparam int NPIX = RS * CS;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic sreset = 1'b1, start = 1'b0, pix_valid = 1'b0, win_ready = 1'b0;
    logic sel = 1'b0;

    logic       pr1, bs1, bc1, wv1, fd1, bz1;
    logic       pr2, bs2, bc2, wv2, fd2, bz2;
    logic [2:0] wr1, wc1, wr2, wc2;

    logic       s_pix_ready, s_buf_shift, s_buf_clear, s_win_valid, s_frame_done, s_busy;
    logic [2:0] s_win_row, s_win_col;

    assign s_pix_ready  = sel ? pr2 : pr1;
    assign s_buf_shift  = sel ? bs2 : bs1;
    assign s_buf_clear  = sel ? bc2 : bc1;
    assign s_win_valid  = sel ? wv2 : wv1;
    assign s_frame_done = sel ? fd2 : fd1;
    assign s_busy       = sel ? bz2 : bz1;
    assign s_win_row    = sel ? wr2 : wr1;
    assign s_win_col    = sel ? wc2 : wc1;

    int checks = 0;
    int errors = 0;

    conv_window_scheduler #(
        .KERNEL_SIZE (K), .ROW_SIZE (RS), .COLUMN_SIZE (CS), .STRIDE (1)
    ) dut_s1 (
        .clock (clock), .sreset (sreset), .start (start), .pix_valid (pix_valid),
        .pix_ready (pr1), .buf_shift (bs1), .buf_clear (bc1), .win_valid (wv1),
        .win_ready (win_ready), .win_row (wr1), .win_col (wc1), .frame_done (fd1),
        .busy (bz1)
    );

    conv_window_scheduler #(
        .KERNEL_SIZE (K), .ROW_SIZE (RS), .COLUMN_SIZE (CS), .STRIDE (2)
    ) dut_s2 (
        .clock (clock), .sreset (sreset), .start (start), .pix_valid (pix_valid),
        .pix_ready (pr2), .buf_shift (bs2), .buf_clear (bc2), .win_valid (wv2),
        .win_ready (win_ready), .win_row (wr2), .win_col (wc2), .frame_done (fd2),
        .busy (bz2)
    );

    task automatic do_reset();
        @(negedge clock);
        sreset = 1'b1; start = 1'b0; pix_valid = 1'b0; win_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        sreset = 1'b0;
    endtask

    // Runs one full frame on the selected instance. Expected behaviour comes from a
    // pixel-index model: the pixel at index i sits at (i / RS, i % RS), and the list of
    // windows is enumerated directly from the stride grid.
    task automatic run_frame(input bit stride2, input int vpct, input int rpct,
                             input bit hold11, input bit start_noise,
                             output int n_win, output bit saw_adv);
        int  s;
        int  q_row[$];
        int  q_col[$];
        int  idx, exp_row, exp_col, hold_cnt, cyc, r, c;
        bit  exp_wv, exp_done, exp_ready, acc, hs, qual, next_done;
        bit  prev_wv;
        int  prev_row, prev_col;
        s = stride2 ? 2 : 1;
        sel = stride2;
        for (int r0 = 0; r0 <= CS - K; r0 += s)
            for (int c0 = 0; c0 <= RS - K; c0 += s) begin
                q_row.push_back(r0);
                q_col.push_back(c0);
            end
        idx = 0; exp_wv = 0; exp_row = 0; exp_col = 0; exp_done = 0; hold_cnt = 0;
        prev_wv = 0; prev_row = 0; prev_col = 0; n_win = 0; saw_adv = 0;

        @(negedge clock);
        start = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
        #1;
        checks++; if (s_pix_ready !== 1'b0 || s_busy !== 1'b0) begin errors++;
            $display("FAIL idle_before_start: pix_ready=%b busy=%b required 0 0", s_pix_ready, s_busy); end
        @(negedge clock);
        start = 1'b0;
        #1;
        checks++; if (s_buf_clear !== 1'b1 || s_busy !== 1'b1) begin errors++;
            $display("FAIL flush_cycle: buf_clear=%b busy=%b required 1 1", s_buf_clear, s_busy); end
        checks++; if (s_pix_ready !== 1'b0 || s_buf_shift !== 1'b0) begin errors++;
            $display("FAIL flush_no_accept: pix_ready=%b buf_shift=%b required 0 0", s_pix_ready, s_buf_shift); end

        for (cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clock);
            pix_valid = (int'($urandom_range(99, 0)) < vpct);
            win_ready = (int'($urandom_range(99, 0)) < rpct);
            if (hold11 && exp_wv && exp_row == 1 && exp_col == 1 && hold_cnt < 5) begin
                win_ready = 1'b0;
                hold_cnt++;
            end
            start = (start_noise && !exp_done) ? 1'($urandom_range(1, 0)) : 1'b0;
            #1;
            exp_ready = (idx < NPIX) && !exp_done && (!exp_wv || win_ready);
            checks++; if (s_pix_ready !== exp_ready) begin errors++;
                $display("FAIL pix_ready idx=%0d: got %b required %b", idx, s_pix_ready, exp_ready); end
            checks++; if (s_buf_shift !== (exp_ready & pix_valid)) begin errors++;
                $display("FAIL buf_shift idx=%0d: got %b required %b", idx, s_buf_shift, exp_ready & pix_valid); end
            checks++; if (s_win_valid !== exp_wv) begin errors++;
                $display("FAIL win_valid idx=%0d: got %b required %b", idx, s_win_valid, exp_wv); end
            if (exp_wv) begin
                checks++; if (s_win_row !== 3'(exp_row) || s_win_col !== 3'(exp_col)) begin errors++;
                    $display("FAIL win_tag: got (%0d,%0d) required (%0d,%0d)", s_win_row, s_win_col, exp_row, exp_col); end
            end
            checks++; if (s_frame_done !== exp_done || s_busy !== !exp_done) begin errors++;
                $display("FAIL frame_state: frame_done=%b busy=%b required %b %b", s_frame_done, s_busy, exp_done, !exp_done); end
            checks++; if (s_buf_clear !== 1'b0) begin errors++;
                $display("FAIL buf_clear_run: got %b required 0", s_buf_clear); end
            if (exp_done) break;

            if (prev_wv && s_win_valid && prev_row == 0 && prev_col == 0 &&
                s_win_row == 3'd0 && s_win_col == 3'd1) saw_adv = 1;
            prev_wv = s_win_valid; prev_row = int'(s_win_row); prev_col = int'(s_win_col);

            if (s_win_valid && win_ready) begin
                n_win++;
                checks++;
                if (q_row.size() == 0) begin errors++;
                    $display("FAIL extra_window: got (%0d,%0d) required none", s_win_row, s_win_col);
                end else begin
                    if (s_win_row !== 3'(q_row[0]) || s_win_col !== 3'(q_col[0])) begin errors++;
                        $display("FAIL window_order: got (%0d,%0d) required (%0d,%0d)", s_win_row, s_win_col, q_row[0], q_col[0]); end
                    void'(q_row.pop_front());
                    void'(q_col.pop_front());
                end
            end

            hs = exp_wv && win_ready;
            acc = exp_ready && pix_valid;
            next_done = (idx == NPIX) && (!exp_wv || win_ready);
            if (acc) begin
                r = idx / RS;
                c = idx % RS;
                qual = (r >= K - 1) && (c >= K - 1) && ((r - (K - 1)) % s == 0) &&
                       ((c - (K - 1)) % s == 0);
                if (qual) begin
                    exp_wv = 1; exp_row = r - (K - 1); exp_col = c - (K - 1);
                end else if (hs) begin
                    exp_wv = 0;
                end
                idx++;
            end else if (hs) begin
                exp_wv = 0;
            end
            exp_done = next_done;
        end
        start = 1'b0;
        if (cyc >= 2000) begin
            checks++; errors++;
            $display("FAIL frame_timeout: got no frame_done in 2000 cycles required frame_done");
        end
        @(negedge clock);
        #1;
        checks++; if (s_frame_done !== 1'b0 || s_busy !== 1'b0) begin errors++;
            $display("FAIL after_done: frame_done=%b busy=%b required 0 0", s_frame_done, s_busy); end
        checks++; if (q_row.size() != 0) begin errors++;
            $display("FAIL missing_windows: got %0d left over required 0", q_row.size()); end
    endtask

    task automatic test_reset();
        @(negedge clock);
        sreset = 1'b1; start = 1'b1; pix_valid = 1'b1; win_ready = 1'b1; sel = 1'b0;
        @(negedge clock);
        #1;
        checks++; if (s_pix_ready !== 1'b0 || s_buf_shift !== 1'b0) begin errors++;
            $display("FAIL reset_ready: pix_ready=%b buf_shift=%b required 0 0", s_pix_ready, s_buf_shift); end
        checks++; if (s_buf_clear !== 1'b1) begin errors++;
            $display("FAIL reset_buf_clear: got %b required 1", s_buf_clear); end
        checks++; if (s_win_valid !== 1'b0 || s_frame_done !== 1'b0 || s_busy !== 1'b0) begin errors++;
            $display("FAIL reset_flags: win_valid=%b frame_done=%b busy=%b required 0 0 0", s_win_valid, s_frame_done, s_busy); end
        checks++; if (s_win_row !== 3'd0 || s_win_col !== 3'd0) begin errors++;
            $display("FAIL reset_tags: got (%0d,%0d) required (0,0)", s_win_row, s_win_col); end
        checks++; if (bc2 !== 1'b1 || bz2 !== 1'b0) begin errors++;
            $display("FAIL reset_s2: buf_clear=%b busy=%b required 1 0", bc2, bz2); end
        start = 1'b0;
        sreset = 1'b0;
        @(negedge clock);
        #1;
        checks++; if (s_buf_clear !== 1'b0 || s_busy !== 1'b0) begin errors++;
            $display("FAIL post_reset_idle: buf_clear=%b busy=%b required 0 0", s_buf_clear, s_busy); end
    endtask

    task automatic test_full_frame();
        int n; bit adv;
        do_reset();
        run_frame(1'b0, 100, 100, 1'b0, 1'b0, n, adv);
        checks++; if (n != 9) begin errors++;
            $display("FAIL s1_window_count: got %0d required 9", n); end
        checks++; if (adv !== 1'b1) begin errors++;
            $display("FAIL s1_tag_advance: got %b required 1", adv); end
    endtask

    task automatic test_stride2();
        int n; bit adv;
        do_reset();
        run_frame(1'b1, 100, 100, 1'b0, 1'b0, n, adv);
        checks++; if (n != 4) begin errors++;
            $display("FAIL s2_window_count: got %0d required 4", n); end
        run_frame(1'b1, 70, 60, 1'b0, 1'b0, n, adv);
        checks++; if (n != 4) begin errors++;
            $display("FAIL s2_random_count: got %0d required 4", n); end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        int n; bit adv;
        do_reset();
        run_frame(1'b0, 100, 100, 1'b1, 1'b0, n, adv);
        checks++; if (n != 9) begin errors++;
            $display("FAIL hold_window_count: got %0d required 9", n); end
    endtask

    task automatic test_back_to_back();
        int n; bit adv;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b0, int'($urandom_range(100, 40)), int'($urandom_range(100, 30)),
                      1'b0, 1'b0, n, adv);
            checks++; if (n != 9) begin errors++;
                $display("FAIL b2b_window_count frame %0d: got %0d required 9", i, n); end
        end
    endtask

    task automatic test_mid_reset();
        int n, acc, cyc; bit adv;
        do_reset();
        sel = 1'b0;
        @(negedge clock);
        start = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        acc = 0;
        for (cyc = 0; cyc < 100 && acc < 10; cyc++) begin
            @(negedge clock);
            #1;
            if (s_buf_shift) acc++;
        end
        checks++; if (acc != 10) begin errors++;
            $display("FAIL mid_reset_accepts: got %0d required 10", acc); end
        @(negedge clock);
        sreset = 1'b1; pix_valid = 1'b0;
        @(negedge clock);
        #1;
        checks++; if (s_busy !== 1'b0 || s_pix_ready !== 1'b0 || s_buf_clear !== 1'b1) begin errors++;
            $display("FAIL mid_reset_state: busy=%b pix_ready=%b buf_clear=%b required 0 0 1", s_busy, s_pix_ready, s_buf_clear); end
        checks++; if (s_win_valid !== 1'b0 || s_frame_done !== 1'b0) begin errors++;
            $display("FAIL mid_reset_flags: win_valid=%b frame_done=%b required 0 0", s_win_valid, s_frame_done); end
        sreset = 1'b0; pix_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            #1;
            checks++; if (s_frame_done !== 1'b0 || s_busy !== 1'b0 || s_pix_ready !== 1'b0) begin errors++;
                $display("FAIL aborted_frame: frame_done=%b busy=%b pix_ready=%b required 0 0 0", s_frame_done, s_busy, s_pix_ready); end
        end
        run_frame(1'b0, 100, 100, 1'b0, 1'b0, n, adv);
        checks++; if (n != 9) begin errors++;
            $display("FAIL after_abort_count: got %0d required 9", n); end
    endtask

    task automatic test_ignored_inputs();
        int n; bit adv;
        do_reset();
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            pix_valid = 1'b1; win_ready = 1'b1; start = 1'b0;
            #1;
            checks++; if (s_pix_ready !== 1'b0 || s_buf_shift !== 1'b0 || s_busy !== 1'b0) begin errors++;
                $display("FAIL idle_pixels: pix_ready=%b buf_shift=%b busy=%b required 0 0 0", s_pix_ready, s_buf_shift, s_busy); end
        end
        run_frame(1'b0, 80, 80, 1'b0, 1'b1, n, adv);
        checks++; if (n != 9) begin errors++;
            $display("FAIL start_noise_count: got %0d required 9", n); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stride2();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_ignored_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
